// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: memory-port stage between the 2A03 core and system memory.
// Passes CPU accesses straight through while idle, and performs the
// 256-byte sprite DMA from page $XX00 to the PPU OAM data port when the
// CPU writes the DMA register. The core is halted for the whole transfer.
module oam_dma_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cpu_addr_l,
    input  logic [7:0] cpu_addr_h,
    input  logic       cpu_rw,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_halt,
    output logic [7:0] mem_addr_l,
    output logic [7:0] mem_addr_h,
    output logic       mem_rw,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       dma_busy
);

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RD    = 2'd2,
        WR    = 2'd3
    } state_t;

    state_t     state;
    logic       odd;
    logic       extra;
    logic       align_done;
    logic       busy_q;
    logic [7:0] page;
    logic [7:0] cnt;
    logic [7:0] data_buf;
    logic       dma_trigger;

    // A CPU write to the DMA register; only acted on while idle
    assign dma_trigger = !cpu_rw && ({cpu_addr_h, cpu_addr_l} == DMA_REG_ADDR);

    // Free-running cycle parity, decides whether an extra alignment cycle is needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odd <= 1'b0;
        end else begin
            odd <= ~odd;
        end
    end

    // DMA sequencer: trigger, alignment, then 256 read/write pairs within one page
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            page       <= 8'h00;
            cnt        <= 8'h00;
            extra      <= 1'b0;
            align_done <= 1'b0;
            data_buf   <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dma_trigger) begin
                        page       <= cpu_wdata;
                        cnt        <= 8'h00;
                        extra      <= odd;
                        align_done <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (extra && !align_done) begin
                        align_done <= 1'b1;
                    end else begin
                        align_done <= 1'b0;
                        state      <= RD;
                    end
                end
                RD: begin
                    state <= WR;
                end
                WR: begin
                    data_buf <= mem_rdata;
                    cnt      <= cnt + 8'd1;
                    if (cnt == 8'hFF) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        state <= RD;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Memory-side bus: pass-through when idle, DMA addresses/data when busy
    always_comb begin
        mem_addr_h = cpu_addr_h;
        mem_addr_l = cpu_addr_l;
        mem_rw     = cpu_rw;
        mem_wdata  = cpu_wdata;
        case (state)
            IDLE: begin
                if (dma_trigger) begin
                    mem_rw = 1'b1;
                end
            end
            ALIGN: begin
                mem_addr_h = DMA_REG_ADDR[15:8];
                mem_addr_l = DMA_REG_ADDR[7:0];
                mem_rw     = 1'b1;
                mem_wdata  = 8'h00;
            end
            RD: begin
                mem_addr_h = page;
                mem_addr_l = cnt;
                mem_rw     = 1'b1;
                mem_wdata  = data_buf;
            end
            WR: begin
                mem_addr_h = OAM_DATA_ADDR[15:8];
                mem_addr_l = OAM_DATA_ADDR[7:0];
                mem_rw     = 1'b0;
                mem_wdata  = mem_rdata;
            end
            default: begin
                mem_rw = 1'b1;
            end
        endcase
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_halt  = busy_q;
    assign dma_busy  = busy_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: a synchronous memory model behind the DMA stage,
// directed CPU stimulus, and a scoreboard of expected OAM write data that a
// separate monitor drains whenever the DUT writes the OAM data port.
module tb_oam_dma_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] cpu_addr_l;
    logic [7:0] cpu_addr_h;
    logic       cpu_rw;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_halt;
    logic [7:0] mem_addr_l;
    logic [7:0] mem_addr_h;
    logic       mem_rw;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       dma_busy;

    logic [7:0]  mem_model [0:65535];
    logic        bd_we;
    logic [15:0] bd_addr;
    logic [7:0]  bd_data;

    logic [7:0]  exp_q [$];
    int          total;
    int          bad;
    int          oam_writes;
    int          dma_start_w;
    logic        tb_odd;
    logic [15:0] last_rd;
    logic        zero_touch;
    logic [15:0] mon_addr;

    oam_dma_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr_l (cpu_addr_l),
        .cpu_addr_h (cpu_addr_h),
        .cpu_rw     (cpu_rw),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_halt   (cpu_halt),
        .mem_addr_l (mem_addr_l),
        .mem_addr_h (mem_addr_h),
        .mem_rw     (mem_rw),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dma_busy   (dma_busy)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memory: read data valid the cycle after the address, plus a backdoor loader
    always @(posedge clk) begin
        if (bd_we) begin
            mem_model[bd_addr] <= bd_data;
        end else if (!mem_rw) begin
            mem_model[{mem_addr_h, mem_addr_l}] <= mem_wdata;
        end
        mem_rdata <= mem_model[{mem_addr_h, mem_addr_l}];
    end

    // Reference parity flop: the value the DUT latches at the next rising edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_odd <= 1'b0;
        end else begin
            tb_odd <= ~tb_odd;
        end
    end

    // Monitor: drains the scoreboard on every OAM write and watches for forbidden accesses
    initial begin
        zero_touch = 1'b0;
        last_rd    = 16'h0000;
        oam_writes = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                mon_addr = {mem_addr_h, mem_addr_l};
                if (mon_addr == 16'h4014) begin
                    total++;
                    if (!mem_rw) begin
                        bad++;
                        $display("[TB] FAIL dma_reg_forwarded: mem_rw=%0d required 1 at $4014", mem_rw);
                    end
                end
                if (cpu_halt && !mem_rw && mon_addr == 16'h2004) begin
                    oam_writes++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL oam_write_unexpected: got %02h with no expected byte", mem_wdata);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (mem_wdata !== e) begin
                            bad++;
                            $display("[TB] FAIL oam_data: write %0d got %02h required %02h",
                                     oam_writes, mem_wdata, e);
                        end
                    end
                end
                if (cpu_halt && mem_rw && mon_addr != 16'h4014) begin
                    last_rd = mon_addr;
                end
                if (cpu_halt && mon_addr == 16'h0000) begin
                    zero_touch = 1'b1;
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic rw, input logic [7:0] wdata);
        @(negedge clk);
        cpu_addr_h = addr[15:8];
        cpu_addr_l = addr[7:0];
        cpu_rw     = rw;
        cpu_wdata  = wdata;
    endtask

    task automatic loadPage(input logic [7:0] page, input logic [7:0] key);
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            bd_we   = 1'b1;
            bd_addr = {page, n[7:0]};
            bd_data = n[7:0] ^ key;
        end
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue a DMA at the chosen parity; abort_at>0 stops at that halted cycle without checks
    task automatic runDma(input logic [7:0] page, input logic [7:0] key, input logic want_odd,
                          input int abort_at);
        int guard;
        int halt_cycles;
        guard = 0;
        @(negedge clk);
        while (tb_odd != want_odd && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        for (int n = 0; n < 256; n++) begin
            exp_q.push_back(n[7:0] ^ key);
        end
        dma_start_w = oam_writes;
        cpu_addr_h = 8'h40;
        cpu_addr_l = 8'h14;
        cpu_rw     = 1'b0;
        cpu_wdata  = page;
        @(negedge clk);
        #1;
        checkOutput("halt_rise", {30'd0, cpu_halt, dma_busy}, 32'h3);
        cpu_wdata = 8'h07;
        halt_cycles = 0;
        guard = 0;
        while (cpu_halt && guard < 700) begin
            halt_cycles++;
            guard++;
            if (halt_cycles == 12) begin
                cpu_addr_h = 8'h01;
                cpu_addr_l = 8'h00;
                cpu_rw     = 1'b1;
                cpu_wdata  = 8'h00;
            end
            if (abort_at != 0 && halt_cycles == abort_at) begin
                break;
            end
            @(negedge clk);
            #1;
        end
        if (abort_at == 0) begin
            checkOutput("halt_len", halt_cycles, 513 + {31'd0, want_odd});
            checkOutput("oam_count", oam_writes - dma_start_w, 256);
            checkOutput("queue_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bd_we      = 1'b0;
        bd_addr    = 16'h0000;
        bd_data    = 8'h00;
        cpu_addr_h = 8'h01;
        cpu_addr_l = 8'h00;
        cpu_rw     = 1'b1;
        cpu_wdata  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_halt", {30'd0, cpu_halt, dma_busy}, 32'h0);
        checkOutput("reset_passthru", {15'd0, mem_rw, mem_addr_h, mem_addr_l}, {15'd0, 1'b1, 16'h0100});
        @(negedge clk);
        rst_n = 1'b1;

        // Preload memory
        loadPage(8'h03, 8'hA5);
        loadPage(8'hFF, 8'h3C);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 16'h0123; bd_data = 8'h77;
        @(negedge clk);
        bd_we = 1'b0;

        // Pass-through write and read
        applyStimulus(16'h0200, 1'b0, 8'h5A);
        #1;
        checkOutput("pt_write_bus", {7'd0, mem_rw, mem_addr_h, mem_addr_l, mem_wdata},
                    {7'd0, 1'b0, 16'h0200, 8'h5A});
        checkOutput("pt_write_halt", {31'd0, cpu_halt}, 0);
        applyStimulus(16'h0123, 1'b1, 8'h00);
        #1;
        checkOutput("pt_write_stored", {24'd0, mem_model[16'h0200]}, 32'h5A);
        @(negedge clk);
        #1;
        checkOutput("pt_read_data", {24'd0, cpu_rdata}, 32'h77);

        // CPU read of the DMA register is passed through and does not trigger
        applyStimulus(16'h4014, 1'b1, 8'h00);
        #1;
        checkOutput("rd4014_bus", {15'd0, mem_rw, mem_addr_h, mem_addr_l}, {15'd0, 1'b1, 16'h4014});
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rd4014_no_dma", {31'd0, cpu_halt}, 0);
        applyStimulus(16'h0100, 1'b1, 8'h00);

        // Even and odd parity DMAs from page $03
        $display("[TB] even-parity DMA page 03");
        runDma(8'h03, 8'hA5, 1'b0, 0);
        $display("[TB] odd-parity DMA page 03");
        runDma(8'h03, 8'hA5, 1'b1, 0);

        // Page $FF: last read is $FFFF, nothing touches $0000
        $display("[TB] DMA page FF");
        runDma(8'hFF, 8'h3C, 1'b0, 0);
        checkOutput("ff_last_read", {16'd0, last_rd}, 32'hFFFF);
        checkOutput("ff_no_zero", {31'd0, zero_touch}, 0);

        // Reset during WR(100)
        $display("[TB] reset mid-DMA");
        runDma(8'h03, 8'hA5, 1'b0, 202);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_halt", {30'd0, cpu_halt, dma_busy}, 0);
        checkOutput("abort_passthru", {15'd0, mem_rw, mem_addr_h, mem_addr_l}, {15'd0, 1'b1, 16'h0100});
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("abort_no_resume", {31'd0, cpu_halt}, 0);
        checkOutput("abort_writes", oam_writes - dma_start_w, 100);

        // Full copy after the aborted one
        $display("[TB] DMA after abort");
        runDma(8'h03, 8'hA5, 1'b0, 0);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Memory-port stage directly downstream of the 2A03 CPU core: sits between the core's `mem_*` pins and system memory, passing CPU accesses through and implementing the 2A03 sprite DMA. A CPU write to the DMA register halts the core and copies 256 bytes from page `$XX00` to the PPU OAM data port, then releases the bus. The top level splits the core's bidirectional `mem_data` into `cpu_wdata`/`cpu_rdata` and gates the core's clock enable with `cpu_halt`.

## Interface
- `DMA_REG_ADDR`, 16'h4014, address whose write starts a DMA; data byte is source page
- `OAM_DATA_ADDR`, 16'h2004, destination address of every DMA write
- `clk`  in  1  system clock; all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `cpu_addr_l`, `cpu_addr_h`  in  8 each  CPU address
- `cpu_rw`  in  1  CPU direction, 1 = read, 0 = write
- `cpu_wdata`  in  8  CPU write data
- `cpu_rdata`  out  8  read data to CPU (= `mem_rdata`)
- `cpu_halt`  out  1  1 = core must not advance
- `mem_addr_l`, `mem_addr_h`  out  8 each  memory address
- `mem_rw`  out  1  memory direction, 1 = read
- `mem_wdata`  out  8  memory write data
- `mem_rdata`  in  8  memory read data, valid the cycle after its address is presented
- `dma_busy`  out  1  1 while a DMA is in progress (equals `cpu_halt`)

## Operation
- States: IDLE, ALIGN, RD, WR. A free-running parity flop `odd` toggles every cycle (reset 0).
- IDLE: `mem_*` outputs are combinational pass-through of `cpu_*`. Exception: a CPU write to `DMA_REG_ADDR` is not forwarded; `mem_rw` stays 1 for that cycle.
- Trigger: in IDLE at a rising edge with `cpu_rw`=0 and `{cpu_addr_h,cpu_addr_l}`=`DMA_REG_ADDR`:
  - latch `page`=`cpu_wdata`
  - clear byte counter `cnt` to 0
  - latch `extra`=`odd`
  - go to ALIGN
- ALIGN: bus idle (`mem_rw`=1, address = `DMA_REG_ADDR`, `mem_wdata`=0). Lasts 1 cycle if `extra`=0, 2 cycles if `extra`=1, then RD.
- RD: `mem_addr`={`page`,`cnt`}, `mem_rw`=1; next state WR.
- WR: `mem_addr`=`OAM_DATA_ADDR`, `mem_rw`=0, `mem_wdata`=`mem_rdata` (data from the RD cycle, also latched into `buf`).
  - `cnt` increments at the end of WR (8-bit).
  - If `cnt` was 8'hFF, go to IDLE (wrap ends transfer); else go to RD.
- Source address never crosses the page: low byte 00..FF, high byte fixed = `page`. Page $FF is legal.
- `cpu_halt`=`dma_busy`=1 in ALIGN, RD, WR; 0 in IDLE. The core is stalled, so no CPU access is honoured while busy; CPU inputs are ignored (including further `DMA_REG_ADDR` writes).
- `cpu_rdata` = `mem_rdata` in all states.

## Timing
- Reset (async assert, sync release): state IDLE, `cnt`=0, `page`=0, `extra`=0, `odd`=0, `buf`=0. `cpu_halt`=0, `dma_busy`=0. `mem_*` follow `cpu_*` immediately.
- Trigger at edge E: `cpu_halt` rises in the cycle after E. It stays high for exactly 513 cycles (`extra`=0) or 514 cycles (`extra`=1), and is low in the first cycle after the 256th WR.
- Order of cycles after ALIGN: RD(0), WR(0), RD(1), …, WR(255). Exactly 256 writes to `OAM_DATA_ADDR`, with byte n equal to memory[{`page`,n}].
- Reset asserted mid-DMA: abort immediately. Outputs return to pass-through and `cpu_halt`=0 asynchronously. No further DMA writes occur, and no resume after release.
- Trigger write and read in the same cycle is impossible (single `cpu_rw`); a CPU read of `DMA_REG_ADDR` is passed through and does not trigger.

## Test plan
- Pass-through: with no DMA, a CPU read of $0123 returns the memory byte; a CPU write of $5A to $0200 stores $5A and `cpu_halt` stays 0.
- Even-parity DMA: fill $0300–$03FF with n^$A5, then write $03 to $4014 with `odd`=0. Expect 256 writes to $2004 of values $A5, $A4, …, in order, and `cpu_halt` high for exactly 513 cycles. $4014 never appears with `mem_rw`=0.
- Odd-parity DMA: same stimulus one cycle later. `cpu_halt` is high for 514 cycles and the data sequence is identical.
- Page $FF and counter wrap: write $FF to $4014. The last source read is $FFFF, the transfer stops after 256 writes, and no access is made to $0000.
- Reset mid-DMA: assert `rst_n`=0 during WR(100). `cpu_halt`=0 the same cycle, the $2004 write count stays 100 after reset, and a new $4014 write then performs a full 256-byte copy.
- Ignored triggers: a CPU read of $4014 causes no DMA. Driving a $4014 write on `cpu_*` while busy does not restart or extend the transfer.
